// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the external-memory arbiter between the I-cache and D-cache refill engines.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IC_XFER = 2'd1,
        ARB_DC_XFER = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IC = 1'b0,
        ARB_OWNER_DC = 1'b1
    } arb_owner_e;

    localparam int ARB_BURST_LEN  = 4;
    localparam int ARB_WORD_OFF_W = 2;

    // Byte-offset width of a line: word index bits plus the byte-in-word bits.
    function automatic int line_off_w(input int cnt_w);
        return cnt_w + ARB_WORD_OFF_W;
    endfunction

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Word counter for one line burst: clear at grant, step on each memory acknowledge, flag the final word.
module mem_arb_burst_cnt #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            // BURST_LEN is a power of two, so the final increment wraps to 0.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory port between I-cache refills and D-cache refill/writeback bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_grant,
    output logic              ic_rvalid,
    output logic              ic_done,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_grant,
    output logic              dc_rvalid,
    output logic              dc_done,

    output logic [CNT_W-1:0]  burst_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int OFF_W  = line_off_w(CNT_W);
    localparam int BASE_W = ADDR_W - OFF_W;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              we_q, we_d;

    logic              xfer;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_last;

    // Line-offset address bits and read data are consumed by the caches, not here.
    logic unused_bits;
    assign unused_bits = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0], mem_rdata};

    assign xfer    = (state_q == ARB_IC_XFER) || (state_q == ARB_DC_XFER);
    assign cnt_inc = xfer && mem_ack;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        we_d    = we_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // owner_q holds the last grant: the other side wins a tie.
                if (dc_req && (!ic_req || owner_q == ARB_OWNER_IC)) begin
                    state_d = ARB_DC_XFER;
                    owner_d = ARB_OWNER_DC;
                    base_d  = dc_addr[ADDR_W-1:OFF_W];
                    we_d    = dc_we;
                    cnt_clr = 1'b1;
                end else if (ic_req && (!dc_req || owner_q == ARB_OWNER_DC)) begin
                    state_d = ARB_IC_XFER;
                    owner_d = ARB_OWNER_IC;
                    base_d  = ic_addr[ADDR_W-1:OFF_W];
                    we_d    = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            ARB_IC_XFER, ARB_DC_XFER: begin
                if (mem_ack && cnt_last) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWNER_IC;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    mem_arb_burst_cnt #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (burst_idx),
        .last_o (cnt_last)
    );

    // Control outputs decode registered state only; strobes follow mem_ack combinationally.
    assign mem_req   = xfer;
    assign ic_grant  = (state_q == ARB_IC_XFER);
    assign dc_grant  = (state_q == ARB_DC_XFER);
    assign ic_done   = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_IC);
    assign dc_done   = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_DC);
    assign mem_we    = we_q && (state_q == ARB_DC_XFER);
    assign mem_addr  = {base_q, burst_idx, 2'b00};
    assign mem_wdata = dc_wdata;

    assign ic_rvalid = mem_ack && (state_q == ARB_IC_XFER);
    assign dc_rvalid = mem_ack && (state_q == ARB_DC_XFER) && !we_q;
    assign dc_wready = mem_ack && (state_q == ARB_DC_XFER) && we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BL     = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_req, dc_req, dc_we, mem_ack;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [DATA_W-1:0] dc_wdata, mem_rdata;
    logic              ic_grant, ic_rvalid, ic_done;
    logic              dc_wready, dc_grant, dc_rvalid, dc_done;
    logic [CNT_W-1:0]  burst_idx;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wready(dc_wready), .dc_grant(dc_grant), .dc_rvalid(dc_rvalid),
        .dc_done(dc_done), .burst_idx(burst_idx), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many words of the line have moved, and whether
    // the one-cycle completion slot is pending. Phase 0 = free, 1 = bursting, 2 = completing.
    int          m_phase = 0;
    bit          m_who   = 0;   // 0 = I-cache, 1 = D-cache
    bit          m_last  = 0;   // requester most recently granted
    bit          m_we    = 0;
    logic [31:0] m_base  = '0;
    int          m_words = 0;

    // Bench-side bookkeeping.
    int          ack_mode = 0;  // 0 always, 1 alternate, 2 random, 3 never
    bit          ack_tog  = 0;
    bit          ic_hold  = 0, dc_hold = 0;
    bit          prev_grant = 0;
    int          ic_done_cnt = 0, dc_done_cnt = 0;
    int          ic_rv_cnt = 0, dc_rv_cnt = 0, dc_wr_cnt = 0;
    logic [31:0] addr_log[$];
    bit          grant_log[$];

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a - (a % (BL * 4));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_who = 0; m_last = 0; m_we = 0; m_base = '0; m_words = 0;
    endtask

    task automatic model_start(input bit who, input logic [31:0] a, input bit we);
        m_phase = 1; m_who = who; m_last = who; m_base = line_base(a); m_we = we; m_words = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        bit busy;
        @(negedge clk);
        busy = (m_phase == 1);
        check_val("mem_req", mem_req, busy);
        check_val("grants", {ic_grant, dc_grant}, {busy && !m_who, busy && m_who});
        check_val("dones", {ic_done, dc_done}, {m_phase == 2 && !m_who, m_phase == 2 && m_who});
        check_val("burst_idx", burst_idx, m_words);
        if (busy) begin
            check_val("mem_addr", mem_addr, m_base + m_words * 4);
            check_val("mem_we", mem_we, m_we);
        end
        check_val("strobes", {ic_rvalid, dc_rvalid, dc_wready},
                  {mem_ack && busy && !m_who, mem_ack && busy && m_who && !m_we,
                   mem_ack && busy && m_who && m_we});
        check_val("mem_wdata", mem_wdata, dc_wdata);

        if (ic_rvalid || dc_rvalid || dc_wready) addr_log.push_back(mem_addr);
        if (ic_rvalid) ic_rv_cnt++;
        if (dc_rvalid) dc_rv_cnt++;
        if (dc_wready) dc_wr_cnt++;
        if ((ic_grant || dc_grant) && !prev_grant) grant_log.push_back(dc_grant);
        prev_grant = ic_grant || dc_grant;
        if (ic_done) begin
            ic_done_cnt++;
            if (!ic_hold) ic_req = 1'b0;
        end
        if (dc_done) begin
            dc_done_cnt++;
            if (!dc_hold) dc_req = 1'b0;
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (dc_req && (!ic_req || m_last == 0)) model_start(1, dc_addr, dc_we);
                    else if (ic_req && (!dc_req || m_last == 1)) model_start(0, ic_addr, 0);
                end
                1: if (mem_ack) begin
                    m_words++;
                    if (m_words == BL) begin
                        m_words = 0;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic step();
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin ack_tog = ~ack_tog; mem_ack = ack_tog; end
            2: mem_ack = ($urandom_range(0, 9) < 6);
            default: mem_ack = 1'b0;
        endcase
        dc_wdata  = $urandom;
        mem_rdata = $urandom;
        cycle();
    endtask

    task automatic wait_ic_done(input string tag, output int n);
        int start = ic_done_cnt;
        n = 0;
        while (ic_done_cnt == start && n < 80) begin step(); n++; end
        if (ic_done_cnt == start) check_val({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_dc_done(input string tag);
        int start = dc_done_cnt;
        int n = 0;
        while (dc_done_cnt == start && n < 80) begin step(); n++; end
        if (dc_done_cnt == start) check_val({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_line(input string tag, input logic [31:0] base);
        check_val({tag, "_words"}, addr_log.size(), BL);
        for (int i = 0; i < BL; i++)
            if (i < addr_log.size()) check_val({tag, "_addr"}, addr_log[i], base + 4 * i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, c1, w0;
        rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_val("reset_outs",
                  {ic_grant, ic_rvalid, ic_done, dc_wready, dc_grant, dc_rvalid, dc_done,
                   burst_idx, mem_req, mem_we, mem_addr, mem_wdata}, 64'h0);
        rst = 1'b0;
        ack_mode = 3;
        step();

        // Lone I-cache refill, zero-wait memory (the ack is also high while idle).
        addr_log.delete(); c0 = ic_rv_cnt;
        ic_addr = 32'h0000_1234; ic_req = 1'b1; ack_mode = 0;
        wait_ic_done("ic_refill", n);
        check_val("ic_done_latency", n, 6);
        check_val("ic_rvalid_count", ic_rv_cnt - c0, BL);
        check_line("ic_refill", 32'h0000_1230);
        ack_mode = 3; step();

        // D-cache writeback with an ack every other cycle.
        addr_log.delete(); c0 = dc_wr_cnt; c1 = dc_done_cnt; ack_tog = 0;
        dc_addr = 32'h80; dc_we = 1'b1; dc_req = 1'b1; ack_mode = 1;
        wait_dc_done("dc_wb");
        ack_mode = 3; repeat (3) step();
        check_val("dc_wready_count", dc_wr_cnt - c0, BL);
        check_val("dc_done_once", dc_done_cnt - c1, 1);
        check_line("dc_wb", 32'h80);

        // Simultaneous requests after reset, both re-requesting: DC first, then strict alternation.
        rst = 1'b1; step(); rst = 1'b0;
        grant_log.delete();
        ic_addr = 32'h0000_0400; dc_addr = 32'h0000_0800; dc_we = 1'b0;
        ic_hold = 1; dc_hold = 1; ic_req = 1; dc_req = 1; ack_mode = 2;
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin step(); n++; end
        check_val("rr_grants_seen", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check_val("rr_order", grant_log[i], (i % 2 == 0));
        ic_hold = 0; dc_hold = 0; ack_mode = 0;
        repeat (20) step();

        // Reset after the second ack of an I-cache burst.
        ic_addr = 32'h0000_4000; ic_req = 1'b1; ack_mode = 0; c0 = ic_rv_cnt; n = 0;
        while (ic_rv_cnt - c0 < 2 && n < 40) begin step(); n++; end
        check_val("rst_mid_acks", ic_rv_cnt - c0, 2);
        c1 = ic_done_cnt;
        rst = 1'b1; ic_req = 1'b0; ack_mode = 3;
        step();
        rst = 1'b0;
        check_val("rst_mid_req", mem_req, 1'b0);
        check_val("rst_mid_grant", ic_grant, 1'b0);
        check_val("rst_mid_idx", burst_idx, 0);
        repeat (3) step();
        check_val("rst_mid_no_done", ic_done_cnt - c1, 0);
        addr_log.delete(); c0 = dc_rv_cnt;
        dc_addr = 32'h0000_2008; dc_we = 1'b0; dc_req = 1'b1; ack_mode = 0;
        wait_dc_done("post_rst_dc");
        check_val("post_rst_dc_rvalid", dc_rv_cnt - c0, BL);
        check_line("post_rst_dc", 32'h0000_2000);
        ack_mode = 3; step();

        // Stray acks with nobody requesting.
        c0 = ic_rv_cnt + dc_rv_cnt + dc_wr_cnt; w0 = grant_log.size(); ack_mode = 0;
        repeat (5) step();
        check_val("stray_strobes", ic_rv_cnt + dc_rv_cnt + dc_wr_cnt - c0, 0);
        check_val("stray_grants", grant_log.size() - w0, 0);

        // Random traffic: requests, holds, wait states and occasional resets.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            ic_hold = ($urandom_range(0, 3) == 0);
            dc_hold = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin ic_req = 0; dc_req = 0; end
            if (!ic_req && $urandom_range(0, 4) == 0) begin
                ic_addr = $urandom; ic_req = 1'b1;
            end
            if (!dc_req && $urandom_range(0, 4) == 0) begin
                dc_addr = $urandom; dc_we = $urandom_range(0, 1); dc_req = 1'b1;
            end
            step();
        end
        rst = 0; ic_hold = 0; dc_hold = 0; ack_mode = 0;
        repeat (30) step();
        check_val("drain_idle", mem_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
